// File: rtl/simd_sequencer.sv
// Instruction sequencer for the SIMD processor: owns the program counter, fetches
// from a synchronous-read instruction memory and presents each instruction to the decoder.
module simd_sequencer #(
    parameter int                      ADDR_WIDTH   = 10,
    parameter int                      OPCODE_WIDTH = 3,
    parameter int                      PC_WIDTH     = 8,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 3'b111,
    parameter logic [OPCODE_WIDTH-1:0] MULTI_OPCODE = 3'b011,
    parameter int                      MULTI_CYCLES = 4,
    localparam int                     INSTR_WIDTH  = OPCODE_WIDTH + 3*ADDR_WIDTH + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PC_WIDTH-1:0]    base_pc,
    input  logic                   stall,
    output logic                   imem_en,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [15:0]            retired
);

    localparam int                CNT_W   = (MULTI_CYCLES > 2) ? $clog2(MULTI_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MULTI_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_DONE
    } state_t;

    state_t                   state, state_nxt;
    logic [INSTR_WIDTH-1:0]   ir;
    logic [CNT_W-1:0]         cnt;
    logic                     run_init;
    logic                     ir_load;
    logic                     cnt_dec;
    logic                     retire;
    logic [OPCODE_WIDTH-1:0]  fetched_op;

    // The retire counter sticks at all-ones instead of wrapping on very long runs.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fetched_op = imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];

    always_comb begin
        state_nxt = state;
        run_init  = 1'b0;
        ir_load   = 1'b0;
        cnt_dec   = 1'b0;
        retire    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    state_nxt = S_FETCH;
                    run_init  = 1'b1;
                end
            end
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT: begin
                ir_load   = 1'b1;
                state_nxt = (fetched_op == HALT_OPCODE) ? S_DONE : S_EXEC;
            end
            S_EXEC: begin
                if (!stall) begin
                    if (cnt != '0) begin
                        cnt_dec = 1'b1;
                    end else begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort overrides everything else that could happen this cycle.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            ir_load   = 1'b0;
            cnt_dec   = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            ir      <= '0;
            cnt     <= '0;
            retired <= '0;
        end else begin
            if (run_init) begin
                pc      <= base_pc;
                retired <= '0;
            end
            if (ir_load) begin
                ir  <= imem_rdata;
                cnt <= (fetched_op == MULTI_OPCODE) ? CNT_MAX : '0;
            end
            if (cnt_dec) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (retire) begin
                pc      <= pc + PC_WIDTH'(1);
                retired <= sat_inc16(retired);
            end
        end
    end

    assign imem_en     = (state == S_FETCH);
    assign imem_addr   = pc;
    assign instr_out   = ir;
    assign instr_valid = (state == S_EXEC);
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_simd_sequencer.sv
// Directed bench for simd_sequencer: per-cycle trace table for a straight program
// plus hand-written sequences for multi-cycle, wrap, abort and async reset.
module tb_simd_sequencer;

    localparam int IW = 34;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          stall = 1'b0;
    logic [7:0]    base_pc = 8'h00;
    logic          imem_en;
    logic [7:0]    imem_addr;
    logic [IW-1:0] imem_rdata = '0;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic [7:0]    pc;
    logic [15:0]   retired;

    logic [IW-1:0] mem [256];
    int errors = 0;
    int checks = 0;

    simd_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .base_pc     (base_pc),
        .stall       (stall),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .pc          (pc),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    typedef struct {
        logic          en;
        logic [7:0]    addr;
        logic          valid;
        logic [IW-1:0] instr;
        logic          dn;
        logic          bsy;
    } vec_t;

    vec_t tv [13];

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [9:0] a,
                                          input logic [9:0] b, input logic [9:0] c,
                                          input logic f);
        return {op, a, b, c, f};
    endfunction

    function automatic vec_t v(input logic en, input logic [7:0] addr, input logic valid,
                               input logic [IW-1:0] instr, input logic dn, input logic bsy);
        vec_t r;
        r.en = en; r.addr = addr; r.valid = valid; r.instr = instr; r.dn = dn; r.bsy = bsy;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // which: 0 = instr_valid, 1 = done
    task automatic wait_for(input int which, input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            start = 1'b0;
            if ((which == 0 && instr_valid) || (which == 1 && done)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic [IW-1:0] i0, i1, i2, hw, mw;
    logic [63:0]   outs_all;
    assign outs_all = {2'b00, imem_en, instr_valid, busy, done, pc, retired, instr_out};

    initial begin
        bit          ok;
        int          vcount, segs, nfetch, seen_done;
        logic        prev_valid;
        logic [7:0]  fa [2];

        i0 = mk(3'b000, 10'h001, 10'h002, 10'h003, 1'b0);
        i1 = mk(3'b001, 10'h3FF, 10'h155, 10'h0AA, 1'b1);
        i2 = mk(3'b010, 10'h200, 10'h011, 10'h022, 1'b1);
        hw = mk(3'b111, 10'h000, 10'h000, 10'h000, 1'b0);
        mw = mk(3'b011, 10'h123, 10'h045, 10'h067, 1'b0);
        for (int a = 0; a < 256; a++) mem[a] = hw;

        tv[0]  = v(1, 8'h10, 0, '0, 0, 1);
        tv[1]  = v(0, 8'h10, 0, '0, 0, 1);
        tv[2]  = v(0, 8'h10, 1, i0, 0, 1);
        tv[3]  = v(1, 8'h11, 0, i0, 0, 1);
        tv[4]  = v(0, 8'h11, 0, i0, 0, 1);
        tv[5]  = v(0, 8'h11, 1, i1, 0, 1);
        tv[6]  = v(1, 8'h12, 0, i1, 0, 1);
        tv[7]  = v(0, 8'h12, 0, i1, 0, 1);
        tv[8]  = v(0, 8'h12, 1, i2, 0, 1);
        tv[9]  = v(1, 8'h13, 0, i2, 0, 1);
        tv[10] = v(0, 8'h13, 0, i2, 0, 1);
        tv[11] = v(0, 8'h13, 0, hw, 1, 1);
        tv[12] = v(0, 8'h13, 0, hw, 0, 0);

        // Reset and idle
        repeat (3) @(negedge clk);
        check("reset outputs", outs_all, 64'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle outputs", outs_all, 64'd0);
        end

        // Straight program, cycle-by-cycle trace
        mem[8'h10] = i0; mem[8'h11] = i1; mem[8'h12] = i2; mem[8'h13] = hw;
        @(negedge clk);
        start = 1'b1; base_pc = 8'h10;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("trace cycle %0d", k + 1),
                  {18'd0, imem_en, imem_addr, instr_valid, instr_out, done, busy},
                  {18'd0, tv[k].en, tv[k].addr, tv[k].valid, tv[k].instr, tv[k].dn, tv[k].bsy});
        end
        check("straight retired", 64'(retired), 64'd3);
        check("straight pc", 64'(pc), 64'h13);

        // Multi-cycle instruction with a two-cycle stall
        mem[8'h00] = mw; mem[8'h01] = hw;
        @(negedge clk);
        start = 1'b1; base_pc = 8'h00;
        vcount = 0; segs = 0; seen_done = 0; prev_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (instr_valid) begin
                vcount++;
                if (!prev_valid) segs++;
                check("multi hold", {22'd0, pc, instr_out}, {22'd0, 8'h00, mw});
            end else if (prev_valid) begin
                check("multi pc after", 64'(pc), 64'h01);
            end
            prev_valid = instr_valid;
            stall = (vcount == 2 || vcount == 3);
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        stall = 1'b0;
        check("multi valid cycles", 64'(vcount), 64'd6);
        check("multi valid segments", 64'(segs), 64'd1);
        check("multi done", 64'(seen_done), 64'd1);
        check("multi retired", 64'(retired), 64'd1);

        // PC wrap from 0xFF to 0x00
        mem[8'hFF] = i0; mem[8'h00] = hw;
        @(negedge clk);
        start = 1'b1; base_pc = 8'hFF;
        nfetch = 0; seen_done = 0; fa[0] = '0; fa[1] = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (imem_en) begin
                if (nfetch < 2) fa[nfetch] = imem_addr;
                nfetch++;
            end
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        check("wrap fetch count", 64'(nfetch), 64'd2);
        check("wrap fetch addrs", {48'd0, fa[0], fa[1]}, {48'd0, 8'hFF, 8'h00});
        check("wrap done", 64'(seen_done), 64'd1);
        check("wrap retired/pc", {40'd0, retired, pc}, {40'd0, 16'd1, 8'h00});

        // Start while busy is ignored; abort mid multi-cycle EXEC
        mem[8'h20] = i1; mem[8'h21] = mw; mem[8'h22] = hw;
        @(negedge clk);
        start = 1'b1; base_pc = 8'h20;
        wait_for(0, 10, ok);
        check("abort first valid", 64'(ok), 64'd1);
        @(negedge clk);
        wait_for(0, 10, ok);
        check("abort second valid", 64'(ok), 64'd1);
        start = 1'b1; base_pc = 8'h55;
        @(negedge clk);
        start = 1'b0;
        check("start while busy", {22'd0, instr_valid, busy, pc, instr_out},
              {22'd0, 1'b1, 1'b1, 8'h21, mw});
        abort = 1'b1; stall = 1'b1;
        @(negedge clk);
        abort = 1'b0; stall = 1'b0;
        check("abort to idle", {44'd0, busy, instr_valid, done, imem_en, retired},
              {44'd0, 4'b0000, 16'd1});
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1;
        end
        check("abort stays idle", 64'(seen_done), 64'd0);
        check("abort retired/pc", {40'd0, retired, pc}, {40'd0, 16'd1, 8'h21});
        start = 1'b1; base_pc = 8'h10;
        wait_for(1, 40, ok);
        check("restart done", 64'(ok), 64'd1);
        check("restart retired", 64'(retired), 64'd3);

        // Asynchronous reset during WAIT
        @(negedge clk);
        start = 1'b1; base_pc = 8'h10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset busy", {63'd0, busy}, 64'd1);
        #2 rst_n = 1'b0;
        #1 check("async reset clear", outs_all, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post-reset idle", {62'd0, busy, imem_en}, 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
